// File: rtl/out_recv.sv
// rtl/out_recv.sv - accumulator-to-stream frame buffer: fill from two lanes, then drain as a stream
//
// Collects FRAME_LEN words written from two accumulator lanes (even/odd
// address) into a frame buffer, then streams the frame out in address order.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset (release synchronized)
//   out_period, out_addr    buffer write strobe and address
//   out_fin                 group-end marker (informational, no state effect)
//   update, acc_in0/1       load strobe and data for the two hold registers
//   m_valid/m_ready/m_data/m_last   output stream
//   busy                    high while the frame is being drained
//   overrun                 sticky: a write arrived while draining
module out_recv #(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          out_period,
  input  logic [5:0]    out_addr,
  input  logic          out_fin,
  input  logic          update,
  input  logic [DW-1:0] acc_in0,
  input  logic [DW-1:0] acc_in1,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          overrun
);

  localparam int             AW       = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [6:0]     FL7      = 7'(FRAME_LEN);
  localparam logic [AW-1:0]  LAST_PTR = AW'(FRAME_LEN - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    rst_sync;
  logic          rst_i;
  logic [DW-1:0] hold0, hold1;
  logic [DW-1:0] mem [FRAME_LEN];
  logic [6:0]    wr_cnt;
  logic [AW-1:0] rd_ptr, rd_addr;
  logic          started;
  logic          wr_en, addr_ok, frame_done, last_beat, load;
  logic [DW-1:0] wdata;
  logic          unused_fin;

  // out_fin only delimits groups upstream; frame completion is count-based.
  assign unused_fin = out_fin;

  // Assertion passes straight through; release is delayed two edges so the
  // first active edge never races the reset removal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  assign busy       = (state == DRAIN);
  assign wr_en      = rst_i && (state == FILL) && out_period;
  assign addr_ok    = ({1'b0, out_addr} < FL7);
  assign frame_done = wr_en && ((wr_cnt + 7'd1) == FL7);
  assign last_beat  = m_valid && m_ready && m_last;

  // A pending update is forwarded straight to the buffer so the first write
  // of a group sees the fresh accumulator values, not the stale hold copy.
  assign wdata = out_addr[0] ? (update ? acc_in1 : hold1)
                             : (update ? acc_in0 : hold0);

  // started gives the one idle cycle after DRAIN entry; the output register
  // then reloads on the first fetch and on every non-final handshake.
  assign load    = (state == DRAIN) && started && (!m_valid || (m_ready && !m_last));
  assign rd_addr = m_valid ? (rd_ptr + AW'(1)) : rd_ptr;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (frame_done) state_nxt = DRAIN;
      DRAIN:   if (last_beat)  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && addr_ok) mem[out_addr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      hold0   <= '0;
      hold1   <= '0;
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      started <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (update) begin
        hold0 <= acc_in0;
        hold1 <= acc_in1;
      end
      if (wr_en) wr_cnt <= frame_done ? 7'd0 : (wr_cnt + 7'd1);
      if ((state == DRAIN) && out_period) overrun <= 1'b1;
      if (frame_done) begin
        rd_ptr  <= '0;
        started <= 1'b0;
      end
      if ((state == DRAIN) && !started) started <= 1'b1;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= mem[rd_addr];
        m_last  <= (rd_addr == LAST_PTR);
        rd_ptr  <= rd_addr;
      end else if (last_beat) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        rd_ptr  <= '0;
        started <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_out_recv.sv
// tb/tb_out_recv.sv - self-checking bench for out_recv (FRAME_LEN=4 and FRAME_LEN=64 instances)
module tb_out_recv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        per[2], fin[2], upd[2], rdy[2];
  logic [5:0]  addr[2];
  logic [15:0] a0[2], a1[2];
  logic        vld[2], lst[2], bsy[2], ovr[2];
  logic [15:0] dat[2];

  always #5 clk = ~clk;

  out_recv #(.DW(16), .FRAME_LEN(4)) u_fl4 (
    .clk(clk), .rst_n(rst_n), .out_period(per[0]), .out_addr(addr[0]), .out_fin(fin[0]),
    .update(upd[0]), .acc_in0(a0[0]), .acc_in1(a1[0]), .m_valid(vld[0]), .m_ready(rdy[0]),
    .m_data(dat[0]), .m_last(lst[0]), .busy(bsy[0]), .overrun(ovr[0]));

  out_recv #(.DW(16), .FRAME_LEN(64)) u_fl64 (
    .clk(clk), .rst_n(rst_n), .out_period(per[1]), .out_addr(addr[1]), .out_fin(fin[1]),
    .update(upd[1]), .acc_in0(a0[1]), .acc_in1(a1[1]), .m_valid(vld[1]), .m_ready(rdy[1]),
    .m_data(dat[1]), .m_last(lst[1]), .busy(bsy[1]), .overrun(ovr[1]));

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int nbeat = 0;
  int nlast = 0;

  // Reference model: frame contents, write count, drain progress in beats,
  // and cycles elapsed since the frame became complete.
  bit          md[2];
  int          mcnt[2], mage[2], midx[2];
  logic [15:0] mhold[2][2];
  logic [15:0] mbuf[2][64];
  bit          mknown[2][64];
  bit          movr[2];
  bit          pv_ok;
  logic        pvalid, pready, plast;
  logic [15:0] pdata;

  typedef struct {
    bit          p;
    logic [5:0]  a;
    bit          u;
    logic [15:0] x0, x1;
    bit          r;
    bit          ev;
    logic [15:0] ed;
    bit          el;
    bit          eb;
  } vec_t;
  vec_t tbl[11];

  function automatic int fl(input int s);
    return (s == 1) ? 64 : 4;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit p, input int a, input bit f, input bit u,
                        input logic [15:0] x0, input logic [15:0] x1, input bit r);
    per[sel] = p; addr[sel] = 6'(a); fin[sel] = f; upd[sel] = u;
    a0[sel] = x0; a1[sel] = x1; rdy[sel] = r;
  endtask

  task automatic tick();
    int s;
    bit ev;
    int k;
    logic [15:0] d;
    s  = sel;
    ev = md[s] && (mage[s] >= 2);
    chk("valid", vld[s], ev);
    chk("busy", bsy[s], md[s]);
    chk("overrun", ovr[s], movr[s]);
    chk("last", lst[s], ev && (midx[s] == fl(s) - 1));
    if (ev && mknown[s][midx[s]]) chk("data", dat[s], mbuf[s][midx[s]]);
    if (pv_ok && pvalid && !pready)
      chk("stall_hold", {vld[s], lst[s], dat[s]}, {1'b1, plast, pdata});
    pv_ok = 1'b1; pvalid = vld[s]; pready = rdy[s]; pdata = dat[s]; plast = lst[s];
    if (vld[s] && rdy[s]) begin
      nbeat++;
      if (lst[s]) nlast++;
    end
    if (md[s]) begin
      if (per[s]) movr[s] = 1'b1;
      if (ev && rdy[s]) begin
        if (midx[s] == fl(s) - 1) begin
          md[s] = 1'b0; midx[s] = 0;
        end else midx[s]++;
      end
      mage[s]++;
    end else if (per[s]) begin
      k = int'(addr[s][0]);
      d = upd[s] ? (k == 1 ? a1[s] : a0[s]) : mhold[s][k];
      if (int'(addr[s]) < fl(s)) begin
        mbuf[s][addr[s]] = d; mknown[s][addr[s]] = 1'b1;
      end
      mcnt[s]++;
      if (mcnt[s] == fl(s)) begin
        md[s] = 1'b1; mage[s] = 0; mcnt[s] = 0; midx[s] = 0;
      end
    end
    if (upd[s]) begin
      mhold[s][0] = a0[s]; mhold[s][1] = a1[s];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      per[i] = 0; addr[i] = 0; fin[i] = 0; upd[i] = 0; a0[i] = 0; a1[i] = 0; rdy[i] = 0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_valid", vld[sel], 1'b0);
    chk("rst_last", lst[sel], 1'b0);
    chk("rst_busy", bsy[sel], 1'b0);
    chk("rst_overrun", ovr[sel], 1'b0);
    chk("rst_data", dat[sel], 16'h0);
    for (int i = 0; i < 2; i++) begin
      md[i] = 0; mcnt[i] = 0; mage[i] = 0; midx[i] = 0; movr[i] = 0;
      mhold[i][0] = 0; mhold[i][1] = 0;
    end
    pv_ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic fill4();
    for (int i = 0; i < 4; i++) begin
      set_in(1, i, i == 3, 1, 16'($urandom), 16'($urandom), 1);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) mknown[i][j] = 1'b0;
    @(negedge clk);
    sel = 0;
    do_reset();

    // Two-group frame with bypass on the first write of each group.
    tbl[0]  = '{1, 6'd0, 1, 16'h00A0, 16'h00A1, 1, 0, 16'h0,    0, 0};
    tbl[1]  = '{1, 6'd1, 0, 16'h0,    16'h0,    1, 0, 16'h0,    0, 0};
    tbl[2]  = '{1, 6'd2, 1, 16'h00B0, 16'h00B1, 1, 0, 16'h0,    0, 0};
    tbl[3]  = '{1, 6'd3, 0, 16'h0,    16'h0,    1, 0, 16'h0,    0, 0};
    tbl[4]  = '{0, 6'd0, 0, 16'h0,    16'h0,    1, 0, 16'h0,    0, 1};
    tbl[5]  = '{0, 6'd0, 0, 16'h0,    16'h0,    1, 0, 16'h0,    0, 1};
    tbl[6]  = '{0, 6'd0, 0, 16'h0,    16'h0,    1, 1, 16'h00A0, 0, 1};
    tbl[7]  = '{0, 6'd0, 0, 16'h0,    16'h0,    1, 1, 16'h00A1, 0, 1};
    tbl[8]  = '{0, 6'd0, 0, 16'h0,    16'h0,    1, 1, 16'h00B0, 0, 1};
    tbl[9]  = '{0, 6'd0, 0, 16'h0,    16'h0,    1, 1, 16'h00B1, 1, 1};
    tbl[10] = '{0, 6'd0, 0, 16'h0,    16'h0,    1, 0, 16'h0,    0, 0};
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].p, int'(tbl[i].a), 0, tbl[i].u, tbl[i].x0, tbl[i].x1, tbl[i].r);
      chk($sformatf("tbl_valid[%0d]", i), vld[0], tbl[i].ev);
      chk($sformatf("tbl_last[%0d]", i), lst[0], tbl[i].el);
      chk($sformatf("tbl_busy[%0d]", i), bsy[0], tbl[i].eb);
      if (tbl[i].ev) chk($sformatf("tbl_data[%0d]", i), dat[0], tbl[i].ed);
      tick();
    end

    // Stalls with ready pattern 1,0,0,1,0,0...
    fill4();
    nbeat = 0; nlast = 0;
    for (int k = 0; k < 40; k++) begin
      set_in(0, 0, 0, 0, 0, 0, (k % 3) == 0);
      tick();
    end
    chk("stall_beats", nbeat, 4);
    chk("stall_lasts", nlast, 1);

    // Write during drain: overrun sets, drained frame untouched, stays set.
    fill4();
    tick();
    set_in(1, 0, 0, 1, 16'hDEAD, 16'hBEEF, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1);
    nbeat = 0;
    repeat (12) tick();
    chk("ovr_beats", nbeat, 4);
    chk("ovr_sticky", ovr[0], 1'b1);

    // Reset mid-drain after two beats, then a clean frame from the start.
    fill4();
    nbeat = 0;
    for (int k = 0; k < 20 && nbeat < 2; k++) tick();
    chk("pre_reset_beats", nbeat, 2);
    do_reset();
    fill4();
    nbeat = 0; nlast = 0;
    repeat (12) tick();
    chk("post_reset_beats", nbeat, 4);
    chk("post_reset_lasts", nlast, 1);

    // out_fin mid-group keeps FILL; out-of-range write counts but is dropped.
    set_in(1, 0, 0, 1, 16'h1110, 16'h1111, 1); tick();
    set_in(1, 1, 1, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick(); tick();
    chk("fin_no_drain", bsy[0], 1'b0);
    set_in(1, 7, 0, 1, 16'h7770, 16'h7771, 1); tick();
    set_in(1, 2, 1, 1, 16'h2220, 16'h2221, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1);
    chk("count_oob_drain", bsy[0], 1'b1);
    repeat (12) tick();

    // Random traffic on the small frame.
    for (int k = 0; k < 3000; k++) begin
      set_in($urandom_range(0, 99) < 60, $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 99) < 30, 16'($urandom), 16'($urandom),
             $urandom_range(0, 99) < 70);
      tick();
    end

    // Full 64-entry frame written as i*8+j, drained in address order.
    sel = 1;
    do_reset();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        set_in(1, i * 8 + j, j == 7, 1, 16'($urandom), 16'($urandom), 1);
        tick();
      end
    set_in(0, 0, 0, 0, 0, 0, 1);
    nbeat = 0; nlast = 0;
    for (int k = 0; k < 200 && (nbeat < 64 || md[1]); k++) tick();
    chk("fl64_beats", nbeat, 64);
    chk("fl64_lasts", nlast, 1);
    chk("fl64_idle", bsy[1], 1'b0);

    // Random traffic on the 64-entry frame.
    for (int k = 0; k < 4000; k++) begin
      set_in($urandom_range(0, 99) < 70, $urandom_range(0, 63), $urandom_range(0, 1),
             $urandom_range(0, 99) < 30, 16'($urandom), 16'($urandom),
             $urandom_range(0, 99) < 75);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
